// File: rtl/parity_sched_pkg.sv
// Shared types and helpers for the parity stream scheduler.
// Pure declarations: no latency, no flow control.
package parity_sched_pkg;

  localparam int PAR_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Round-robin pick: first set bit of valid searching upward from last_grant+1.
  // Iterating from the far end lets the nearest candidate overwrite the others.
  function automatic int rr_pick(input logic [31:0] valid, input int last_grant, input int num_req);
    int idx;
    rr_pick = last_grant;
    for (int i = num_req; i >= 1; i--) begin
      idx = (last_grant + i) % num_req;
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/parity16_tree.sv
// Shared 16-bit even-parity evaluator: XOR reduction of one beat.
// Purely combinational (zero latency), no flow control.
module parity16_tree
  import parity_sched_pkg::*;
(
  input  logic [PAR_WORD_W-1:0] data,
  output logic                  parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_stream_sched.sv
// Round-robin, packet-locked scheduler streaming beats through one parity evaluator.
// Result one cycle after the last beat; result held stable under res_ready backpressure, beats stalled meanwhile.
module parity_stream_sched
  import parity_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int ERR_CNT_W = 8,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*PAR_WORD_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_exp,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ID_W-1:0]               res_id,
  output logic                          res_parity,
  output logic                          res_err,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic                          busy
);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic                  acc_q, acc_d;
  logic                  par_q, par_d;
  logic                  exp_q, exp_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic [PAR_WORD_W-1:0] beat_data;
  logic                  beat_par;
  logic                  beat_hs;
  logic                  pkt_err;

  // Only the granted requester's beat ever reaches the evaluator.
  assign beat_data = req_data[grant_q*PAR_WORD_W +: PAR_WORD_W];

  parity16_tree u_parity16_tree (
    .data   (beat_data),
    .parity (beat_par)
  );

  assign beat_hs   = (state_q == STREAM) && req_valid[grant_q];
  assign pkt_err   = par_q ^ exp_q;
  assign err_count = err_count_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    par_d        = par_q;
    exp_d        = exp_q;
    err_count_d  = err_count_q;
    req_ready    = '0;
    res_valid    = 1'b0;
    res_id       = '0;
    res_parity   = 1'b0;
    res_err      = 1'b0;
    busy         = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = ID_W'(rr_pick(32'(req_valid), 32'(last_grant_q), NUM_REQ));
          acc_d   = 1'b0;
          state_d = STREAM;
        end
      end

      STREAM: begin
        busy               = 1'b1;
        req_ready[grant_q] = 1'b1;
        if (beat_hs) begin
          acc_d = acc_q ^ beat_par;
          if (req_last[grant_q]) begin
            par_d   = acc_q ^ beat_par;
            exp_d   = req_exp[grant_q];
            state_d = REPORT;
          end
        end
      end

      REPORT: begin
        busy       = 1'b1;
        res_valid  = 1'b1;
        res_id     = grant_q;
        res_parity = par_q;
        res_err    = pkt_err;
        if (res_ready) begin
          if (pkt_err && !(&err_count_q)) err_count_d = err_count_q + ERR_CNT_W'(1);
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      acc_q        <= 1'b0;
      par_q        <= 1'b0;
      exp_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      par_q        <= par_d;
      exp_q        <= exp_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_parity_stream_sched.sv
// Directed bench for parity_stream_sched (NUM_REQ=4, ERR_CNT_W=2 so saturation is reachable).
// Inputs are driven and outputs sampled on the falling edge.
module tb_parity_stream_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, req_last, req_exp;
  logic [63:0] req_data;
  logic        res_valid, res_ready;
  logic [1:0]  res_id;
  logic        res_parity, res_err;
  logic [1:0]  err_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int exp_err = 0;

  parity_stream_sched #(.NUM_REQ(4), .ERR_CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_exp    (req_exp),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_parity (res_parity),
    .res_err    (res_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_beat(input int r, input logic v, input logic [15:0] d, input logic l, input logic e);
    req_valid[r]         = v;
    req_data[r*16 +: 16] = d;
    req_last[r]          = l;
    req_exp[r]           = e;
  endtask

  // Serves single-beat packets until n results are seen; ids packed 2 bits each, first in [1:0].
  task automatic run_packets(input string name, input int n, input logic [7:0] want_ids);
    logic [3:0] clr;
    logic [1:0] ids [4];
    int got;
    clr = '0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
      @(negedge clk);
      req_valid = req_valid & ~clr;
      clr = '0;
      if (res_valid && res_ready) begin
        ids[got] = res_id;
        got++;
      end
      for (int r = 0; r < 4; r++)
        if (req_ready[r] && req_valid[r] && req_last[r]) clr[r] = 1'b1;
    end
    @(negedge clk);
    total++;
    if (got !== n) begin bad++; $display("FAIL %s_count got=%0d want=%0d", name, got, n); end
    for (int k = 0; k < got; k++) begin
      total++;
      if (ids[k] !== want_ids[2*k +: 2]) begin
        bad++; $display("FAIL %s_id%0d got=%0d want=%0d", name, k, ids[k], want_ids[2*k +: 2]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'($urandom);
    req_last  = 4'($urandom);
    req_exp   = 4'($urandom);
    req_data  = {$urandom, $urandom};
    res_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0000", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", res_valid); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL rst_res_id got=%0d want=0", res_id); end
    total++; if (res_parity !== 1'b0) begin bad++; $display("FAIL rst_res_parity got=%b want=0", res_parity); end
    total++; if (res_err !== 1'b0) begin bad++; $display("FAIL rst_res_err got=%b want=0", res_err); end
    total++; if (err_count !== 2'd0) begin bad++; $display("FAIL rst_err_count got=%0d want=0", err_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    req_valid = '0; req_last = '0; req_exp = '0; req_data = '0; res_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || req_ready !== 4'b0) begin
        bad++; $display("FAIL idle_after_rst cyc%0d busy=%b ready=%b want busy=0 ready=0000", i, busy, req_ready);
      end
    end
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 4; r++) set_beat(r, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_packets("rr_all", 4, 8'hE4);
    set_beat(1, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_packets("rr_one", 1, 8'h01);
    set_beat(0, 1'b1, 16'h0000, 1'b1, 1'b0);
    set_beat(3, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_packets("rr_wrap", 2, 8'h03);
    total++; if (err_count !== 2'(exp_err)) begin bad++; $display("FAIL rr_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  task automatic test_single_beat();
    set_beat(0, 1'b1, 16'h0001, 1'b1, 1'b1);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001 || busy !== 1'b1) begin
      bad++; $display("FAIL sb_ready got=%b busy=%b want=0001 busy=1", req_ready, busy); end
    @(negedge clk);
    set_beat(0, 1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL sb_res_valid got=%b want=1", res_valid); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL sb_res_id got=%0d want=0", res_id); end
    total++; if (res_parity !== 1'b1) begin bad++; $display("FAIL sb_res_parity got=%b want=1", res_parity); end
    total++; if (res_err !== 1'b0) begin bad++; $display("FAIL sb_res_err got=%b want=0", res_err); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL sb_ready_report got=%b want=0000", req_ready); end
    @(negedge clk);
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL sb_done res_valid=%b busy=%b want 0 0", res_valid, busy); end
    total++; if (err_count !== 2'(exp_err)) begin bad++; $display("FAIL sb_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  task automatic test_multi_beat_err();
    set_beat(2, 1'b1, 16'h00FF, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mb_grant got=%b want=0100", req_ready); end
    set_beat(1, 1'b1, 16'h0003, 1'b1, 1'b0);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      req_valid[2] = 1'b0;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mb_gap%0d_ready got=%b want=0100", g, req_ready); end
    end
    @(negedge clk);
    set_beat(2, 1'b1, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    set_beat(2, 1'b1, 16'h8000, 1'b1, 1'b1);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mb_lock_ready got=%b want=0100", req_ready); end
    @(negedge clk);
    set_beat(2, 1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin
      bad++; $display("FAIL mb_res got valid=%b id=%0d want valid=1 id=2", res_valid, res_id); end
    total++; if (res_parity !== 1'b0) begin bad++; $display("FAIL mb_res_parity got=%b want=0", res_parity); end
    total++; if (res_err !== 1'b1) begin bad++; $display("FAIL mb_res_err got=%b want=1", res_err); end
    total++; if (err_count !== 2'(exp_err)) begin bad++; $display("FAIL mb_err_before got=%0d want=%0d", err_count, exp_err); end
    exp_err = 1;
    @(negedge clk);
    total++; if (err_count !== 2'(exp_err)) begin bad++; $display("FAIL mb_err_after got=%0d want=%0d", err_count, exp_err); end
    total++; if (res_valid !== 1'b0 || req_ready !== 4'b0) begin
      bad++; $display("FAIL mb_idle got valid=%b ready=%b want 0 0000", res_valid, req_ready); end
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mb_req1_grant got=%b want=0010", req_ready); end
    @(negedge clk);
    set_beat(1, 1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (res_id !== 2'd1 || res_err !== 1'b0 || res_parity !== 1'b0) begin
      bad++; $display("FAIL mb_req1_res got id=%0d err=%b par=%b want 1 0 0", res_id, res_err, res_parity); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    set_beat(3, 1'b1, 16'h0007, 1'b1, 1'b0);
    @(negedge clk);
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant got=%b want=1000", req_ready); end
    @(negedge clk);
    set_beat(3, 1'b0, 16'h0000, 1'b0, 1'b0);
    set_beat(0, 1'b1, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (res_valid !== 1'b1 || res_id !== 2'd3 || res_parity !== 1'b1 || res_err !== 1'b1 ||
          req_ready !== 4'b0 || err_count !== 2'(exp_err)) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b id=%0d par=%b err=%b rdy=%b cnt=%0d want 1 3 1 1 0000 %0d",
                 i, res_valid, res_id, res_parity, res_err, req_ready, err_count, exp_err);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    exp_err = 2;
    @(negedge clk);
    total++; if (err_count !== 2'(exp_err) || res_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got cnt=%0d v=%b want %0d 0", err_count, res_valid, exp_err); end
    run_packets("bp_next", 1, 8'h00);
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 4; p++) begin
      set_beat(1, 1'b1, 16'h0001, 1'b1, 1'b0);
      run_packets("sat_pkt", 1, 8'h01);
      if (exp_err < 3) exp_err++;
      total++; if (err_count !== 2'(exp_err)) begin
        bad++; $display("FAIL sat_cnt%0d got=%0d want=%0d", p, err_count, exp_err); end
    end
  endtask

  task automatic test_reset_mid_packet();
    set_beat(2, 1'b1, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rmp_grant got=%b want=0100", req_ready); end
    @(negedge clk);
    set_beat(2, 1'b1, 16'h0011, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_err = 0;
    total++; if (req_ready !== 4'b0 || res_valid !== 1'b0 || busy !== 1'b0 || err_count !== 2'd0 ||
                 res_id !== 2'd0 || res_parity !== 1'b0 || res_err !== 1'b0) begin
      bad++; $display("FAIL rmp_outputs got rdy=%b v=%b busy=%b cnt=%0d want all 0",
                      req_ready, res_valid, busy, err_count);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rmp_no_res%0d got=%b want=0", i, res_valid); end
    end
    set_beat(0, 1'b1, 16'h0000, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001 || res_valid !== 1'b0) begin
      bad++; $display("FAIL rmp_regrant got rdy=%b v=%b want 0001 0", req_ready, res_valid); end
    @(negedge clk);
    set_beat(0, 1'b0, 16'h0000, 1'b0, 1'b0);
    set_beat(2, 1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin
      bad++; $display("FAIL rmp_res got v=%b id=%0d want 1 0", res_valid, res_id); end
    @(negedge clk);
    total++; if (err_count !== 2'(exp_err)) begin bad++; $display("FAIL rmp_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_beat();
    test_multi_beat_err();
    test_backpressure();
    test_saturation();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
